cv32e41p_illegal_evt_fifo: RTL and testbench

CV32E41P_ILLEGAL_EVT_FIFO -- requirements
Module: cv32e41p_illegal_evt_fifo

---
 rtl/cv32e41p_illegal_evt_fifo.sv | 133 +++++++++++++
 tb/tb_cv32e41p_illegal_evt_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_illegal_evt_fifo.sv
// Illegal-instruction event FIFO: captures {pc, instr, timestamp}
// for each new illegal instruction seen in ID and queues it for a logger.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   is_decoding_i         ID holds a valid instruction this cycle
//   illegal_insn_dec_i    decoder marks the ID instruction illegal
//   pc_id_i, instr_id_i   PC and instruction word in ID
//   evt_valid_o           head entry present (valid/ready with evt_ready_i)
//   evt_pc_o              head entry PC
//   evt_instr_o           head entry instruction word
//   evt_cycle_o           head entry capture timestamp
//   illegal_cnt_o         captured events, wraps
//   drop_cnt_o            events lost to a full FIFO, saturates at 0xFFFF
//
// Build option: CV32E41P_ILLEGAL_EVT_TIMESTAMP_EN adds a free-running
// cycle counter and per-entry timestamp; without it evt_cycle_o is 0.
module cv32e41p_illegal_evt_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        is_decoding_i,
  input  logic        illegal_insn_dec_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] instr_id_i,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic [31:0] evt_pc_o,
  output logic [31:0] evt_instr_o,
  output logic [31:0] evt_cycle_o,
  output logic [31:0] illegal_cnt_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic        qual_q;
  logic [31:0] last_pc_q;
  logic [31:0] illegal_cnt;
  logic [15:0] drop_cnt;

  logic qual;
  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A stalled illegal instruction stays qualified at the same PC;
  // only the first cycle of such a run is captured.
  assign qual    = is_decoding_i && illegal_insn_dec_i;
  assign capture = qual && (!qual_q || (pc_id_i != last_pc_q));

  assign full = (occ == CW'(DEPTH));
  assign pop  = evt_valid_o && evt_ready_i;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      qual_q      <= 1'b0;
      last_pc_q   <= '0;
      illegal_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      qual_q <= qual;
      if (capture) begin
        last_pc_q   <= pc_id_i;
        illegal_cnt <= illegal_cnt + 32'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      pc_mem[wr_ptr]    <= pc_id_i;
      instr_mem[wr_ptr] <= instr_id_i;
    end
  end

`ifdef CV32E41P_ILLEGAL_EVT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign evt_cycle_o = ts_mem[rd_ptr];
`else
  assign evt_cycle_o = 32'd0;
`endif

  assign evt_valid_o   = (occ != '0);
  assign evt_pc_o      = pc_mem[rd_ptr];
  assign evt_instr_o   = instr_mem[rd_ptr];
  assign illegal_cnt_o = illegal_cnt;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_cv32e41p_illegal_evt_fifo.sv
// Bench for cv32e41p_illegal_evt_fifo: vector table, directed
// sequences and random traffic against a queue-based reference.
module tb_cv32e41p_illegal_evt_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        is_decoding_i;
  logic        illegal_insn_dec_i;
  logic [31:0] pc_id_i;
  logic [31:0] instr_id_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [31:0] evt_pc_o;
  logic [31:0] evt_instr_o;
  logic [31:0] evt_cycle_o;
  logic [31:0] illegal_cnt_o;
  logic [15:0] drop_cnt_o;

  always #5 clk = ~clk;

  cv32e41p_illegal_evt_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .is_decoding_i      (is_decoding_i),
    .illegal_insn_dec_i (illegal_insn_dec_i),
    .pc_id_i            (pc_id_i),
    .instr_id_i         (instr_id_i),
    .evt_valid_o        (evt_valid_o),
    .evt_ready_i        (evt_ready_i),
    .evt_pc_o           (evt_pc_o),
    .evt_instr_o        (evt_instr_o),
    .evt_cycle_o        (evt_cycle_o),
    .illegal_cnt_o      (illegal_cnt_o),
    .drop_cnt_o         (drop_cnt_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] stamp;
  } evt_t;

  typedef struct {
    logic        r;
    logic        d;
    logic        il;
    logic [31:0] pc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ecnt;
  } vec_t;

  evt_t        q[$];
  int unsigned m_cnt;
  int unsigned m_drop;
  int unsigned m_ts;
  bit          m_prevq;
  logic [31:0] m_lastpc;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle and advance the reference on the same edge.
  task automatic step(input logic r, input logic d, input logic il,
                      input logic [31:0] p, input logic [31:0] ins,
                      input logic rdy);
    bit qual, cap, pop, was_full;
    evt_t e;
    rst_i              = r;
    is_decoding_i      = d;
    illegal_insn_dec_i = il;
    pc_id_i            = p;
    instr_id_i         = ins;
    evt_ready_i        = rdy;
    if (r) begin
      q.delete();
      m_cnt    = 0;
      m_drop   = 0;
      m_ts     = 0;
      m_prevq  = 0;
      m_lastpc = '0;
    end else begin
      qual     = d && il;
      cap      = qual && (!m_prevq || p != m_lastpc);
      pop      = (q.size() > 0) && rdy;
      was_full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (cap) begin
        m_cnt++;
        m_lastpc = p;
        e.pc     = p;
        e.instr  = ins;
`ifdef CV32E41P_ILLEGAL_EVT_TIMESTAMP_EN
        e.stamp  = m_ts;
`else
        e.stamp  = 32'd0;
`endif
        if (!was_full || pop) q.push_back(e);
        else m_drop++;
      end
      m_prevq = qual;
      m_ts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_drop;
    exp_drop = (m_drop > 65535) ? 32'hFFFF : m_drop;
    check({tag, ".valid"}, {31'd0, evt_valid_o}, {31'd0, q.size() > 0});
    if (q.size() > 0 && evt_valid_o) begin
      check({tag, ".pc"},    evt_pc_o,    q[0].pc);
      check({tag, ".instr"}, evt_instr_o, q[0].instr);
      check({tag, ".cycle"}, evt_cycle_o, q[0].stamp);
    end
    check({tag, ".cnt"},  illegal_cnt_o,      m_cnt);
    check({tag, ".drop"}, {16'd0, drop_cnt_o}, exp_drop);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic evt(input logic [31:0] p, input logic rdy);
    step(1'b0, 1'b1, 1'b1, p, ~p, rdy);
  endtask

  logic [31:0] pcs[4];
  logic [31:0] exp_ts;

  initial begin
    tbl[0]  = '{1, 0, 0, 32'h000, 0, 0, 32'h000, 0};
    tbl[1]  = '{0, 1, 1, 32'h100, 1, 1, 32'h100, 1};
    tbl[2]  = '{0, 0, 0, 32'h000, 1, 0, 32'h000, 1};
    tbl[3]  = '{1, 1, 1, 32'h200, 0, 0, 32'h000, 0};
    tbl[4]  = '{0, 1, 1, 32'h200, 0, 1, 32'h200, 1};
    tbl[5]  = '{0, 1, 1, 32'h200, 0, 1, 32'h200, 1};
    tbl[6]  = '{0, 1, 1, 32'h200, 0, 1, 32'h200, 1};
    tbl[7]  = '{0, 1, 1, 32'h200, 0, 1, 32'h200, 1};
    tbl[8]  = '{0, 1, 1, 32'h200, 0, 1, 32'h200, 1};
    tbl[9]  = '{0, 1, 1, 32'h204, 0, 1, 32'h200, 2};
    tbl[10] = '{0, 0, 0, 32'h000, 1, 1, 32'h204, 2};
    tbl[11] = '{0, 0, 0, 32'h000, 1, 0, 32'h000, 2};
    tbl[12] = '{0, 1, 0, 32'h300, 1, 0, 32'h000, 2};
    tbl[13] = '{0, 0, 1, 32'h304, 1, 0, 32'h000, 2};

    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].il, tbl[i].pc,
           32'h0, tbl[i].rdy);
      check($sformatf("tbl%0d.valid", i), {31'd0, evt_valid_o},
            {31'd0, tbl[i].ev});
      if (tbl[i].ev)
        check($sformatf("tbl%0d.pc", i), evt_pc_o, tbl[i].epc);
      check($sformatf("tbl%0d.cnt", i), illegal_cnt_o, tbl[i].ecnt);
      check($sformatf("tbl%0d.drop", i), {16'd0, drop_cnt_o}, 32'd0);
    end

    // Six distinct events into a 4-deep FIFO with no consumer.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) evt(32'h300 + 32'(4 * i), 1'b0);
    check("ovf.drop", {16'd0, drop_cnt_o}, 32'd2);
    check("ovf.cnt", illegal_cnt_o, 32'd6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf.pc%0d", i), evt_pc_o, 32'h300 + 32'(4 * i));
      check($sformatf("ovf.v%0d", i), {31'd0, evt_valid_o}, 32'd1);
      idle(1'b1);
    end
    check("ovf.empty", {31'd0, evt_valid_o}, 32'd0);

    // Full FIFO with push and pop in the same cycle.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) evt(32'h400 + 32'(4 * i), 1'b0);
    evt(32'h480, 1'b1);
    check("pp.drop", {16'd0, drop_cnt_o}, 32'd0);
    check("pp.cnt", illegal_cnt_o, 32'd5);
    pcs[0] = 32'h404;
    pcs[1] = 32'h408;
    pcs[2] = 32'h40C;
    pcs[3] = 32'h480;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp.pc%0d", i), evt_pc_o, pcs[i]);
      check($sformatf("pp.v%0d", i), {31'd0, evt_valid_o}, 32'd1);
      idle(1'b1);
    end
    check("pp.empty", {31'd0, evt_valid_o}, 32'd0);

    // Reset pulse with three queued entries and a live handshake.
    for (int i = 0; i < 3; i++) evt(32'h500 + 32'(4 * i), 1'b0);
    check("flush.pre", {31'd0, evt_valid_o}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h600, 32'h0, 1'b1);
    check("flush.valid", {31'd0, evt_valid_o}, 32'd0);
    check("flush.cnt", illegal_cnt_o, 32'd0);
    idle(1'b0);
    check("flush.after", {31'd0, evt_valid_o}, 32'd0);

    // Event ten cycles after reset release.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    evt(32'h700, 1'b0);
`ifdef CV32E41P_ILLEGAL_EVT_TIMESTAMP_EN
    exp_ts = 32'd10;
`else
    exp_ts = 32'd0;
`endif
    check("ts.cycle", evt_cycle_o, exp_ts);
    check_model("ts");

    // Saturation of the drop counter.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH + 65540; i++)
      evt(32'h800 + 32'(4 * (i % 2)), 1'b0);
    check("sat.drop", {16'd0, drop_cnt_o}, 32'h0000FFFF);
    check_model("sat");

    // Random traffic against the reference queue.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_model("rnd.rst");
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           32'h10 + 32'(4 * $urandom_range(0, 2)),
           $urandom,
           $urandom_range(0, 2) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
